// File: rtl/arb_pkg.sv
// Shared types and defaults for the ring buffer write arbiter.
// Defaults match the streaming ring buffer configuration.
package arb_pkg;
    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    localparam int ARB_NUM_REQ    = 4;
    localparam int ARB_DATA_WIDTH = 8;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: rotates the request vector so the
// search starts one past last_owner, then priority-encodes the lowest bit.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_owner,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any
);
    logic [NUM_REQ-1:0] rot;
    logic               hit;
    int                 start;
    int                 idx;

    always_comb begin
        start = int'(last_owner) + 1;
        if (start >= NUM_REQ) start = 0;
        rot = NUM_REQ'({req, req} >> start);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                idx = i + start;
            end
        end
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        winner = ID_WIDTH'(idx);
    end

    assign any = |req;
endmodule

// File: rtl/ring_buffer_write_arbiter.sv
// Message-granular round-robin arbiter for the ring buffer write port.
// Define ARB_BURST_LIMIT_EN to also release a grant after MAX_BURST beats.
module ring_buffer_write_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_valid,
    input  logic                          fifo_ready,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [ID_WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_WIDTH-1:0] win;
    logic                any_req;
    logic                xfer;
    logic                burst_hit;
    logic                rel;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (req_valid),
        .last_owner (last_q),
        .winner     (win),
        .any        (any_req)
    );

    // Owner's stream is passed straight through; nothing moves while idle.
    always_comb begin
        fifo_data  = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        fifo_valid = 1'b0;
        req_ready  = '0;
        if (state_q == LOCKED) begin
            fifo_valid         = req_valid[owner_q];
            req_ready[owner_q] = fifo_ready;
        end
    end

    assign xfer = fifo_valid && fifo_ready;

`ifdef ARB_BURST_LIMIT_EN
    assign burst_hit = xfer && (cnt_q == CNT_W'(MAX_BURST - 1));
`else
    assign burst_hit = 1'b0;
`endif

    assign rel = xfer && (req_last[owner_q] || burst_hit);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = LOCKED;
                    owner_d = win;
                    last_d  = win;
                end
            end
            LOCKED: begin
                if (rel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (xfer && cnt_q != CNT_W'(MAX_BURST)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == LOCKED);
endmodule

// File: tb/tb_ring_buffer_write_arbiter.sv
// Scoreboard bench for ring_buffer_write_arbiter (4 requesters, 8-bit beats).
// Expected beats are queued as {id, data} and popped on each fifo handshake.
module tb_ring_buffer_write_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_last = '0;
    logic [NR-1:0] req_ready;
    logic [DW-1:0] fifo_data;
    logic          fifo_valid;
    logic          fifo_ready = 1'b1;
    logic [1:0]    grant_id;
    logic          busy;

    ring_buffer_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_ready (fifo_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int xfers = 0;
    int first_x = -1;
    int last_x = -1;
    int done_cyc = 0;
    logic rst_cmd = 1'b0;
    logic rdy_cmd = 1'b1;

    logic [DW-1:0] src_mem [NR][16];
    int src_len [NR];
    int src_ptr [NR];
    logic [9:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic load(input int i, input int base, input int n);
        for (int k = 0; k < n; k++) src_mem[i][k] = DW'(base + k);
        src_len[i] = n;
        src_ptr[i] = 0;
    endtask

    task automatic expect_msg(input int i, input int base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({2'(i), DW'(base + k)});
    endtask

    task automatic clear_stats();
        xfers = 0;
        first_x = -1;
        last_x = -1;
    endtask

    task automatic monitor();
        logic [9:0] e;
        check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
        if (busy && !fifo_ready) begin
            check("stall_ready", 32'(req_ready), 0);
            check("stall_valid", 32'(fifo_valid), 1);
        end
        if (fifo_valid && fifo_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'(fifo_data), 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("xfer_id", 32'(grant_id), 32'(e[9:8]));
                check("xfer_data", 32'(fifo_data), 32'(e[7:0]));
            end
            for (int i = 0; i < NR; i++)
                if (req_valid[i] && req_ready[i]) src_ptr[i]++;
            xfers++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = rst_cmd;
        fifo_ready = rdy_cmd;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = src_ptr[i] < src_len[i];
            req_data[i*DW +: DW] = src_mem[i][src_ptr[i] & 15];
            req_last[i] = src_ptr[i] == src_len[i] - 1;
        end
        @(negedge clk);
        monitor();
    endtask

    function automatic bit all_sent();
        for (int i = 0; i < NR; i++)
            if (src_ptr[i] < src_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_drain(input string tag);
        int budget = 300;
        do begin
            step();
            budget--;
        end while (!(all_sent() && !busy && exp_q.size() == 0) && budget > 0);
        if (budget == 0) check({tag, "_timeout"}, 0, 1);
        done_cyc = cyc;
        check({tag, "_sb_left"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_xfers(input int n);
        int budget = 100;
        while (xfers < n && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("wait_xfers_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_cmd = 1'b0;
        step();
        step();
        rst_cmd = 1'b1;
    endtask

    int t0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
            for (int k = 0; k < 16; k++) src_mem[i][k] = '0;
        end

        // Reset held with every requester valid
        for (int i = 0; i < NR; i++) load(i, 8'h10 * (i + 1), 1);
        for (int i = 0; i < NR; i++) expect_msg(i, 8'h10 * (i + 1), 1);
        repeat (3) step();
        check("rst_busy", 32'(busy), 0);
        check("rst_fvalid", 32'(fifo_valid), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_gid", 32'(grant_id), 0);
        rst_cmd = 1'b1;
        step();
        check("arb_cycle_busy", 32'(busy), 0);
        step();
        check("grant_busy", 32'(busy), 1);
        check("grant_gid0", 32'(grant_id), 0);
        run_drain("reset_rr");

        // Single 3-beat message from req1
        clear_stats();
        t0 = cyc;
        load(1, 8'h41, 3);
        expect_msg(1, 8'h41, 3);
        run_drain("single");
        check("single_first", 32'(first_x - t0), 2);
        check("single_span", 32'(last_x - first_x), 2);
        check("single_busy_drop", 32'(done_cyc - last_x), 1);

        // Contention: 0, 2, 3 from fresh reset, then 0 again
        do_reset();
        clear_stats();
        t0 = cyc;
        load(0, 8'h50, 2);
        load(2, 8'h60, 2);
        load(3, 8'h70, 2);
        expect_msg(0, 8'h50, 2);
        expect_msg(2, 8'h60, 2);
        expect_msg(3, 8'h70, 2);
        run_drain("contend");
        check("contend_first", 32'(first_x - t0), 2);
        check("contend_span", 32'(last_x - first_x), 7);
        check("contend_xfers", 32'(xfers), 6);
        load(0, 8'h58, 2);
        expect_msg(0, 8'h58, 2);
        run_drain("regrant0");

        // Backpressure for 5 cycles mid-message
        clear_stats();
        load(2, 8'h20, 6);
        expect_msg(2, 8'h20, 6);
        wait_xfers(2);
        rdy_cmd = 1'b0;
        repeat (5) step();
        check("stall_hold", 32'(xfers), 2);
        rdy_cmd = 1'b1;
        run_drain("stall");
        check("stall_xfers", 32'(xfers), 6);

        // Burst limit: req0 10 beats, req1 2 beats
        do_reset();
        clear_stats();
        load(0, 8'h00, 10);
        load(1, 8'h80, 2);
`ifdef ARB_BURST_LIMIT_EN
        expect_msg(0, 8'h00, 4);
        expect_msg(1, 8'h80, 2);
        expect_msg(0, 8'h04, 4);
        expect_msg(0, 8'h08, 2);
`else
        expect_msg(0, 8'h00, 10);
        expect_msg(1, 8'h80, 2);
`endif
        run_drain("burst");
        check("burst_xfers", 32'(xfers), 12);

        // Reset mid-message after 2 of 5 beats
        clear_stats();
        load(0, 8'hc0, 5);
        expect_msg(0, 8'hc0, 5);
        wait_xfers(2);
        rst_cmd = 1'b0;
        step();
        exp_q.delete();
        src_len[0] = 0;
        src_ptr[0] = 0;
        load(0, 8'ha0, 1);
        load(3, 8'hd0, 1);
        expect_msg(0, 8'ha0, 1);
        expect_msg(3, 8'hd0, 1);
        rst_cmd = 1'b1;
        step();
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_fvalid", 32'(fifo_valid), 0);
        step();
        check("rst_mid_gid", 32'(grant_id), 0);
        run_drain("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_buffer_write_arbiter.md
# ring_buffer_write_arbiter

Round-robin arbiter that shares the single write port of the streaming ring buffer among several byte-stream requesters, such as the command responder, status reporter and debug echo. It grants one requester at a time and holds the grant for a whole message, marked by `req_last`, so bytes from different sources never interleave in the UART TX stream. It sits between the requesters and the ring buffer's `in_data/in_valid/in_ready` port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: beat width.
- `MAX_BURST`, 16: beat limit per grant; used only with `ARB_BURST_LIMIT_EN`.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of `grant_id`.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_last`  in  NUM_REQ  per-requester end-of-message flag, qualified by valid.
- `req_ready`  out  NUM_REQ  per-requester ready; at most one bit is high.
- `fifo_data`  out  DATA_WIDTH  to ring buffer `in_data`.
- `fifo_valid`  out  1  to ring buffer `in_valid`.
- `fifo_ready`  in  1  from ring buffer `in_ready`.
- `grant_id`  out  ID_WIDTH  index of the current owner; holds its last value while idle.
- `busy`  out  1  high while a grant is held.

## Operation
- FSM states:
  - IDLE: no owner.
  - LOCKED: an owner is streaming.
- IDLE, no `req_valid`: stay in IDLE.
- IDLE, any `req_valid`: pick the winner by round-robin, starting the search at `(last_owner+1) mod NUM_REQ`. Register `owner` and `last_owner` as the winner, then go to LOCKED.
- LOCKED datapath, combinational pass-through of the owner:
  - `fifo_data = req_data[owner]`
  - `fifo_valid = req_valid[owner]`
  - `req_ready[owner] = fifo_ready`
  - all other `req_ready` bits are 0.
- A beat transfers when `fifo_valid && fifo_ready`. Each transfer increments `beat_cnt`, which is `$clog2(MAX_BURST+1)` bits and saturates.
- Release: a transfer with `req_last[owner]=1` moves LOCKED to IDLE and clears `beat_cnt`.
- An owner dropping `req_valid` mid-message does not release the grant; the arbiter waits indefinitely.
- In IDLE, `fifo_valid=0` and all `req_ready` bits are 0. No data passes during the arbitration cycle.
- Fairness: the requester granted last has the lowest priority in the next arbitration. With all requesters continuously valid, grants rotate 0,1,2,3,0,...

## Timing
- Reset, synchronous while `rst_n=0`:
  - state = IDLE; `owner`, `grant_id` = 0.
  - `last_owner` = NUM_REQ-1, so requester 0 has first priority.
  - `beat_cnt` = 0; `busy`, `fifo_valid` and all `req_ready` bits = 0.
- Grant latency: `req_valid` seen in IDLE in cycle N gives LOCKED with `busy=1` and a valid `grant_id` in cycle N+1. The first beat can transfer in cycle N+1.
- A message of L beats with no backpressure occupies L+1 cycles: 1 arbitration cycle plus L data cycles. There is exactly one IDLE bubble between consecutive grants.
- `fifo_ready=0` (ring buffer full): no transfer and the state holds. Pass-through means the stall appears at the owner in the same cycle.
- Last beat and a new request from another requester in the same cycle: release happens first. Arbitration of the new request runs in the following IDLE cycle.
- Reset asserted mid-message: the grant is dropped immediately. The partial message already written stays in the ring buffer; that buffer is not cleared by this block.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - A transfer that brings `beat_cnt` to MAX_BURST also releases the grant, even without `req_last`.
  - The owner re-competes later, rotated to the lowest priority.
  - This allows interleaving but bounds latency for the other requesters.
- `ARB_BURST_LIMIT_EN` undefined: release happens only on `req_last`. `MAX_BURST` and `beat_cnt` are unused and may be optimized away.

## Structure
- Shared package `arb_pkg`:
  - state enum {IDLE, LOCKED};
  - default NUM_REQ and DATA_WIDTH constants shared with the ring buffer.
- Sub-module `rr_pick`: purely combinational one-hot round-robin selector.
  - Inputs: `req` vector and `last_owner`.
  - Outputs: `winner` index and `any`.
  - Implemented as a double-width mask/priority-encode, so it can be tested standalone.

## Test plan
- Reset: hold `rst_n=0` with all `req_valid=1` → `busy=0`, `fifo_valid=0`, `req_ready=0`. First release of reset → `grant_id=0` one cycle later.
- Single message: req1 sends 0x41,0x42,0x43 with last on 0x43, `fifo_ready=1` → those three bytes appear on `fifo_data` in consecutive cycles after a 1-cycle grant. `busy` drops the cycle after 0x43.
- Contention: req0, req2 and req3 are all valid with 2-beat messages → grant order 0,2,3. Then req0 reasserts → granted 0 again. Each grant is preceded by one idle cycle.
- Backpressure: `fifo_ready=0` for 5 cycles mid-message → the owner's `req_ready=0`, no beat is lost or duplicated, and the message completes in order.
- Burst limit (`ARB_BURST_LIMIT_EN`, MAX_BURST=4): req0 sends 10 beats and req1 sends 2 → observed order is 4×req0, 2×req1, 4×req0, 2×req0.
- Reset mid-message: assert `rst_n=0` after 2 of 5 beats → next cycle IDLE with `busy=0`. After reset, req0 wins the first grant.
